// File: rtl/mem_pkg.sv
// Shared SRAM memory-path definitions: access sizes, IO addresses, arbiter encodings.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] IO_PORT_ADDR = 32'hffff_ff00;
  localparam logic [31:0] IO_UART_ADDR = 32'hffff_ff01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_COOL  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

  // Command presented to the controller, held for the whole transaction.
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } mc_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the SRAM controller; data has priority with starvation guard.
// Ack one cycle after mc_valid, next mc_req three cycles after mc_valid; requests wait while busy.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mc_req,
  output logic        mc_rw,
  output logic [31:0] mc_addr,
  output logic [1:0]  mc_size,
  output logic [31:0] mc_wdata,
  input  logic [31:0] mc_rdata,
  input  logic        mc_valid
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

  arb_state_t    state, state_nxt;
  gnt_t          gnt, gnt_nxt;
  mc_cmd_t       cmd, cmd_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt, tmo_inc;
  logic          mc_req_nxt, i_ack_nxt, d_ack_nxt, err_nxt;
  logic [31:0]   i_rdata_nxt, d_rdata_nxt;
  logic          arb_en, pick_i, pick_d;

  assign mc_rw    = cmd.rw;
  assign mc_addr  = cmd.addr;
  assign mc_size  = cmd.size;
  assign mc_wdata = cmd.wdata;

  assign pick_i  = i_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign pick_d  = d_req && !pick_i;
  assign tmo_inc = tmo_cnt + 1'b1;
  // COOL arbitrates too, so a pending request reaches the controller exactly
  // three cycles after mc_valid (ACK and COOL cover the controller's recovery).
  assign arb_en  = (state == ST_IDLE) || (state == ST_COOL);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    cmd_nxt     = cmd;
    starve_nxt  = starve_cnt;
    tmo_nxt     = tmo_cnt;
    mc_req_nxt  = 1'b0;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    err_nxt     = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;

    case (state)
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mc_valid) begin
          if (gnt == GNT_I) begin
            i_rdata_nxt = mc_rdata;
            i_ack_nxt   = 1'b1;
          end else begin
            d_rdata_nxt = mc_rdata;
            d_ack_nxt   = 1'b1;
          end
          state_nxt = ST_ACK;
        end else if (tmo_inc == TMO_MAX) begin
          if (gnt == GNT_I) begin
            i_rdata_nxt = '0;
            i_ack_nxt   = 1'b1;
          end else begin
            d_rdata_nxt = '0;
            d_ack_nxt   = 1'b1;
          end
          err_nxt   = 1'b1;
          state_nxt = ST_ACK;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end
      ST_ACK: state_nxt = ST_COOL;
      ST_COOL: begin
        tmo_nxt   = '0;
        gnt_nxt   = GNT_NONE;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (arb_en && pick_i) begin
      cmd_nxt    = '{rw: 1'b0, addr: i_addr, size: SZ_WORD, wdata: 32'h0};
      gnt_nxt    = GNT_I;
      starve_nxt = '0;
      tmo_nxt    = '0;
      mc_req_nxt = 1'b1;
      state_nxt  = ST_ISSUE;
    end else if (arb_en && pick_d) begin
      cmd_nxt    = '{rw: d_rw, addr: d_addr, size: d_size, wdata: d_wdata};
      gnt_nxt    = GNT_D;
      tmo_nxt    = '0;
      mc_req_nxt = 1'b1;
      state_nxt  = ST_ISSUE;
      if (!i_req)
        starve_nxt = '0;
      else if (starve_cnt != STARVE_MAX)
        starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gnt        <= GNT_NONE;
      cmd        <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mc_req     <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      cmd        <= cmd_nxt;
      starve_cnt <= starve_nxt;
      tmo_cnt    <= tmo_nxt;
      mc_req     <= mc_req_nxt;
      i_ack      <= i_ack_nxt;
      d_ack      <= d_ack_nxt;
      err        <= err_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hand-driven controller model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mc_req;
  logic        mc_rw;
  logic [31:0] mc_addr;
  logic [1:0]  mc_size;
  logic [31:0] mc_wdata;
  logic [31:0] mc_rdata = '0;
  logic        mc_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mc_req(mc_req), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_size(mc_size),
    .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_valid(mc_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for mc_req; n is the number of cycles it took.
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (mc_req !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(mc_req), 32'h1);
  endtask

  // Controller: mc_valid with rd lat cycles after the mc_req cycle; returns in the ACK cycle.
  task automatic mc_reply(input int lat, input logic [31:0] rd);
    tick();
    chk("mc_req_one_cycle", 32'(mc_req), 32'h0);
    repeat (lat - 1) tick();
    mc_rdata = rd;
    mc_valid = 1'b1;
    tick();
    mc_valid = 1'b0;
    mc_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mc"}, {28'h0, mc_req, mc_rw, mc_size}, 32'h0);
    chk({tag, "_mc_addr"}, mc_addr, 32'h0);
    chk({tag, "_mc_wdata"}, mc_wdata, 32'h0);
    chk({tag, "_acks"}, {29'h0, i_ack, d_ack, err}, 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] exp_addr [6];

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Fetch read, controller latency 6
    i_req = 1'b1;
    i_addr = 32'h20;
    wait_req("fetch_req_seen", n);
    chk("fetch_issue_lat", n, 32'd1);
    chk("fetch_rw_size", {29'h0, mc_rw, mc_size}, 32'h2);
    chk("fetch_addr", mc_addr, 32'h20);
    chk("fetch_wdata", mc_wdata, 32'h0);
    mc_reply(6, 32'h0000_0013);
    chk("fetch_ack", {30'h0, i_ack, d_ack}, 32'h2);
    chk("fetch_rdata", i_rdata, 32'h0000_0013);
    chk("fetch_err", 32'(err), 32'h0);
    i_req = 1'b0;
    tick();
    chk("fetch_ack_pulse", 32'(i_ack), 32'h0);
    repeat (2) tick();

    // Simultaneous requests: data first, fetch mc_req at N+3
    i_req = 1'b1;
    d_req = 1'b1;
    d_rw = 1'b1;
    d_addr = 32'h100;
    d_size = 2'd0;
    d_wdata = 32'hAB;
    wait_req("sim_req_seen", n);
    chk("sim_data_first", mc_addr, 32'h100);
    chk("sim_rw_size", {29'h0, mc_rw, mc_size}, 32'h4);
    chk("sim_wdata", mc_wdata, 32'hAB);
    mc_reply(3, 32'h0);
    chk("sim_d_ack", {30'h0, i_ack, d_ack}, 32'h1);
    d_req = 1'b0;
    tick();
    chk("sim_gap_n2", 32'(mc_req), 32'h0);
    tick();
    chk("sim_fetch_n3", 32'(mc_req), 32'h1);
    chk("sim_fetch_addr", mc_addr, 32'h20);
    chk("sim_fetch_rw", 32'(mc_rw), 32'h0);
    mc_reply(2, 32'h55);
    chk("sim_i_ack", {30'h0, i_ack, d_ack}, 32'h2);
    chk("sim_i_rdata", i_rdata, 32'h55);
    i_req = 1'b0;
    repeat (3) tick();

    // Starvation: D,D,D,D,I,D
    exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h40, 32'h200};
    i_addr = 32'h40;
    d_addr = 32'h200;
    d_rw = 1'b0;
    d_size = 2'd2;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_req("starve_req_seen", n);
      chk($sformatf("starve_grant%0d", g), mc_addr, exp_addr[g]);
      mc_reply(1, 32'(g));
      if (exp_addr[g] == 32'h40)
        chk($sformatf("starve_ack%0d", g), {30'h0, i_ack, d_ack}, 32'h2);
      else
        chk($sformatf("starve_ack%0d", g), {30'h0, i_ack, d_ack}, 32'h1);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) tick();

    // Field stability; requestor also drops req mid-transaction
    d_req = 1'b1;
    d_rw = 1'b0;
    d_addr = 32'h300;
    d_size = 2'd1;
    wait_req("stab_req_seen", n);
    d_addr = 32'h999;
    d_rw = 1'b1;
    d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stab_addr_wait", mc_addr, 32'h300);
      chk("stab_rw_wait", 32'(mc_rw), 32'h0);
    end
    mc_rdata = 32'h0000_BEEF;
    mc_valid = 1'b1;
    tick();
    mc_valid = 1'b0;
    mc_rdata = '0;
    chk("stab_addr_ack", mc_addr, 32'h300);
    chk("stab_d_ack", {30'h0, i_ack, d_ack}, 32'h1);
    chk("stab_half_zext", d_rdata, 32'h0000_BEEF);
    repeat (3) tick();

    // Timeout after 255 WAIT cycles
    d_req = 1'b1;
    d_rw = 1'b0;
    d_addr = 32'hffff_ff01;
    d_size = 2'd0;
    wait_req("tmo_req_seen", n);
    d_req = 1'b0;
    repeat (255) tick();
    chk("tmo_not_early", {30'h0, d_ack, err}, 32'h0);
    tick();
    chk("tmo_ack_err", {30'h0, d_ack, err}, 32'h3);
    chk("tmo_rdata", d_rdata, 32'h0);
    tick();
    chk("tmo_err_pulse", {30'h0, d_ack, err}, 32'h0);
    d_req = 1'b1;
    d_rw = 1'b1;
    d_addr = 32'hffff_ff00;
    d_wdata = 32'h5A;
    wait_req("post_tmo_req_seen", n);
    chk("post_tmo_addr", mc_addr, 32'hffff_ff00);
    chk("post_tmo_wdata", mc_wdata, 32'h5A);
    mc_reply(2, 32'h0);
    chk("post_tmo_ack", {30'h0, d_ack, err}, 32'h2);
    d_req = 1'b0;
    repeat (3) tick();

    // Reset during WAIT
    d_req = 1'b1;
    d_rw = 1'b0;
    d_addr = 32'h400;
    d_size = 2'd2;
    wait_req("rst_req_seen", n);
    d_req = 1'b0;
    repeat (2) tick();
    chk("rst_pre_addr", mc_addr, 32'h400);
    reset = 1'b0;
    tick();
    chk_all_zero("rst_wait");
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_no_ack", {30'h0, i_ack, d_ack}, 32'h0);
    end
    i_req = 1'b1;
    i_addr = 32'h80;
    wait_req("rst_after_req_seen", n);
    chk("rst_after_addr", mc_addr, 32'h80);
    mc_reply(4, 32'h1234);
    chk("rst_after_ack", {30'h0, i_ack, d_ack}, 32'h2);
    chk("rst_after_rdata", i_rdata, 32'h1234);
    i_req = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
